// File: rtl/kws_mel_pkg.sv
// Shared types and the default 17-entry mel (band, weight) table for the keyword-spotting front end.
// Each used bin sends weight w/256 of its power to band j and (256-w)/256 to band j-1.
package kws_mel_pkg;

    localparam int MEL_FFT_SIZE     = 32;
    localparam int MEL_NUM_BANDS    = 8;
    localparam int MEL_NUM_BINS     = MEL_FFT_SIZE / 2 + 1;
    localparam int MEL_ACC_WIDTH    = 40;
    localparam int MEL_WEIGHT_WIDTH = 9;
    localparam int MEL_J_WIDTH      = $clog2(MEL_NUM_BANDS + 1);

    typedef logic [31:0]                        power_t;
    typedef logic [MEL_ACC_WIDTH-1:0]           acc_t;
    typedef logic [$clog2(MEL_NUM_BANDS)-1:0]   band_idx_t;
    typedef logic [MEL_J_WIDTH-1:0]             band_j_t;
    typedef logic [MEL_WEIGHT_WIDTH-1:0]        weight_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_SEND
    } drain_state_t;

    // j == MEL_NUM_BANDS means the upper half of the triangle falls off the top band
    localparam band_j_t MEL_BAND_J [MEL_NUM_BINS] = '{
        4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
        4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8
    };

    localparam weight_t MEL_WEIGHT [MEL_NUM_BINS] = '{
        9'd256, 9'd64,  9'd192, 9'd64,  9'd192, 9'd128, 9'd224, 9'd96, 9'd192,
        9'd64,  9'd160, 9'd240, 9'd64,  9'd160, 9'd32,  9'd128, 9'd0
    };

endpackage

// File: rtl/mel_coeff_rom.sv
// Registered lookup of the mel (band, weight) pair for one FFT bin.
// Bins above FFT_SIZE/2 return zero; their data never reaches the banks anyway.
module mel_coeff_rom
    import kws_mel_pkg::*;
#(
    parameter int FFT_SIZE = MEL_FFT_SIZE
) (
    input  logic                        clock,
    input  logic [$clog2(FFT_SIZE)-1:0] bin,
    output band_j_t                     band_j,
    output weight_t                     weight
);

    localparam int BIN_WIDTH = $clog2(FFT_SIZE);

    always_ff @(posedge clock) begin
        if (bin <= BIN_WIDTH'(FFT_SIZE / 2)) begin
            band_j <= MEL_BAND_J[bin];
            weight <= MEL_WEIGHT[bin];
        end else begin
            band_j <= '0;
            weight <= '0;
        end
    end

endmodule

// File: rtl/mel_filterbank.sv
// Mel filterbank: |X[k]|^2 of the FFT stream, triangular band accumulation into a
// double-buffered bank, and a ready/valid drain of NUM_BANDS energies per frame.
module mel_filterbank
    import kws_mel_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FFT_SIZE     = MEL_FFT_SIZE,
    parameter int NUM_BANDS    = MEL_NUM_BANDS,
    parameter int WEIGHT_WIDTH = MEL_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = MEL_ACC_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_real_in,
    input  logic signed [DATA_WIDTH-1:0] data_imag_in,
    output logic                         band_valid,
    input  logic                         band_ready,
    output logic [ACC_WIDTH-1:0]         band_data,
    output logic [$clog2(NUM_BANDS)-1:0] band_idx,
    output logic                         band_last,
    output logic                         overflow
);

    localparam int BIN_WIDTH  = $clog2(FFT_SIZE);
    localparam int IDX_WIDTH  = $clog2(NUM_BANDS);
    localparam int HALF       = FFT_SIZE / 2;
    localparam int PROD_WIDTH = 32 + WEIGHT_WIDTH;
    localparam int UNITY      = 1 << (WEIGHT_WIDTH - 1);

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                     input power_t               inc);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, acc} + (ACC_WIDTH + 1)'(inc);
        return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    endfunction

    logic [BIN_WIDTH-1:0]         bin_cnt;
    logic                         vld_p1, last_p1;
    logic signed [DATA_WIDTH-1:0] re_p1, im_p1;
    band_j_t                      j_p1;
    weight_t                      w_p1;
    logic                         vld_p2, last_p2;
    power_t                       pow_p2;
    band_j_t                      j_p2;
    logic [WEIGHT_WIDTH-1:0]      w_p2;
    logic                         vld_p3, last_p3;
    power_t                       hi_p3, lo_p3;
    band_j_t                      j_p3;
    logic                         swap_p4;

    logic signed [2*DATA_WIDTH-1:0] sq_re, sq_im;
    power_t                         pow_c;
    logic [WEIGHT_WIDTH-1:0]        w_inv;
    logic [PROD_WIDTH-1:0]          prod_hi, prod_lo;
    power_t                         inc [NUM_BANDS];

    logic [ACC_WIDTH-1:0] bank [2][NUM_BANDS];
    logic                 fill_sel;

    drain_state_t         state, state_next;
    logic [IDX_WIDTH-1:0] idx, idx_next;
    logic                 handshake, final_hs, swap_go, drop;

    mel_coeff_rom #(
        .FFT_SIZE (FFT_SIZE)
    ) u_rom (
        .clock  (clock),
        .bin    (bin_cnt),
        .band_j (j_p1),
        .weight (w_p1)
    );

    // Bins beyond FFT_SIZE/2 advance the counter but never become valid in the pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            vld_p3  <= 1'b0;
            last_p3 <= 1'b0;
            swap_p4 <= 1'b0;
        end else begin
            if (valid_in) bin_cnt <= bin_cnt + 1'b1;
            vld_p1  <= valid_in && (bin_cnt <= BIN_WIDTH'(HALF));
            last_p1 <= valid_in && (bin_cnt == BIN_WIDTH'(HALF));
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            vld_p3  <= vld_p2;
            last_p3 <= last_p2;
            swap_p4 <= vld_p3 && last_p3;
        end
    end

    // p1 -> p2: power; (-32768)^2 * 2 = 2^31 still fits unsigned 32
    assign sq_re = re_p1 * re_p1;
    assign sq_im = im_p1 * im_p1;
    assign pow_c = power_t'(sq_re) + power_t'(sq_im);

    // p2 -> p3: split the power between band j and band j-1
    assign w_inv   = WEIGHT_WIDTH'(UNITY) - w_p2;
    assign prod_hi = PROD_WIDTH'(pow_p2) * PROD_WIDTH'(w_p2);
    assign prod_lo = PROD_WIDTH'(pow_p2) * PROD_WIDTH'(w_inv);

    always_ff @(posedge clock) begin
        re_p1  <= data_real_in;
        im_p1  <= data_imag_in;
        pow_p2 <= pow_c;
        j_p2   <= j_p1;
        w_p2   <= w_p1;
        hi_p3  <= power_t'(prod_hi >> (WEIGHT_WIDTH - 1));
        lo_p3  <= power_t'(prod_lo >> (WEIGHT_WIDTH - 1));
        j_p3   <= j_p2;
    end

    // p3 -> bank: j == NUM_BANDS drops hi, j == 0 drops lo, simply by having no matching band
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            inc[b] = '0;
            if (vld_p3) begin
                if (j_p3 == band_j_t'(b))          inc[b] = hi_p3;
                else if (j_p3 == band_j_t'(b + 1)) inc[b] = lo_p3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++)
                for (int b = 0; b < NUM_BANDS; b++)
                    bank[1'(k)][IDX_WIDTH'(b)] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANDS; b++)
                bank[fill_sel][IDX_WIDTH'(b)] <= sat_add(bank[fill_sel][IDX_WIDTH'(b)], inc[b]);
            if (swap_go) begin
                for (int b = 0; b < NUM_BANDS; b++)
                    bank[~fill_sel][IDX_WIDTH'(b)] <= '0;
            end else if (drop) begin
                for (int b = 0; b < NUM_BANDS; b++)
                    bank[fill_sel][IDX_WIDTH'(b)] <= '0;
            end
        end
    end

    // A frame end coinciding with the last drain handshake still counts as a free drain
    always_comb begin
        state_next = state;
        idx_next   = idx;
        swap_go    = 1'b0;
        drop       = 1'b0;
        handshake  = (state == DRAIN_SEND) && band_ready;
        final_hs   = handshake && (idx == IDX_WIDTH'(NUM_BANDS - 1));
        if (handshake) idx_next = final_hs ? '0 : idx + 1'b1;
        if (final_hs) state_next = DRAIN_IDLE;
        if (swap_p4) begin
            if ((state == DRAIN_IDLE) || final_hs) begin
                swap_go    = 1'b1;
                state_next = DRAIN_SEND;
                idx_next   = '0;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= DRAIN_IDLE;
            idx      <= '0;
            fill_sel <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (swap_go) fill_sel <= ~fill_sel;
            if (drop)    overflow <= 1'b1;
        end
    end

    assign band_valid = (state == DRAIN_SEND);
    assign band_idx   = idx;
    assign band_last  = band_valid && (idx == IDX_WIDTH'(NUM_BANDS - 1));
    assign band_data  = band_valid ? bank[~fill_sel][idx] : '0;

endmodule
